// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the UART boot loader.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [BYTE_W-1:0] HS_BYTE_DEF  = 8'hAA;
  localparam logic [BYTE_W-1:0] ACK_BYTE_DEF = 8'h55;
  localparam logic [BYTE_W-1:0] ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [2:0] {
    ST_SEND_HS  = 3'd0,
    ST_WAIT_HS  = 3'd1,
    ST_RX_COUNT = 3'd2,
    ST_RX_WORD  = 3'd3,
    ST_SEND_END = 3'd4,
    ST_WAIT_END = 3'd5,
    ST_DONE     = 3'd6
  } loader_state_e;

endpackage

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed little-endian word image from the UART into
// instruction memory, bracketed by a handshake byte and an ACK/ERR byte.
module uart_boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 14,
  parameter logic [BYTE_W-1:0] HS_BYTE  = HS_BYTE_DEF,
  parameter logic [BYTE_W-1:0] ACK_BYTE = ACK_BYTE_DEF,
  parameter logic [BYTE_W-1:0] ERR_BYTE = ERR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  loader_state_e     state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] word_full_c;
  logic              last_byte_c;
  logic              cnt_zero_c;
  logic              cnt_big_c;
  logic              tx_idle_c;

  // Bytes arrive LSB first, so each new byte enters at the top.
  assign word_full_c = {rx_data, word_q[WORD_W-1:BYTE_W]};
  assign last_byte_c = rx_valid && (byte_cnt_q == 2'd3);
  assign cnt_zero_c  = (word_full_c == '0);
  assign cnt_big_c   = (33'(word_full_c) > (33'(1) << ADDR_W));
  // The cycle tx_start is high is skipped so the transmitter can raise busy.
  assign tx_idle_c   = !tx_start_q && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SEND_HS;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SEND_HS:  if (!tx_busy) state_d = ST_WAIT_HS;
      ST_WAIT_HS:  if (tx_idle_c) state_d = ST_RX_COUNT;
      ST_RX_COUNT: if (last_byte_c) state_d = (cnt_zero_c || cnt_big_c) ? ST_SEND_END : ST_RX_WORD;
      ST_RX_WORD:  if (last_byte_c && (idx_q == last_q)) state_d = ST_SEND_END;
      ST_SEND_END: if (!tx_busy) state_d = ST_WAIT_END;
      ST_WAIT_END: if (tx_idle_c) state_d = ST_DONE;
      ST_DONE:     state_d = ST_DONE;
      default:     state_d = ST_SEND_HS;
    endcase
  end

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    idx_d        = idx_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_d        = err_q;
    unique case (state_q)
      ST_SEND_HS: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = HS_BYTE;
        end
      end
      ST_RX_COUNT: begin
        if (rx_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = word_full_c;
        end
        if (last_byte_c) begin
          last_d = ADDR_W'(word_full_c - 32'd1);
          err_d  = cnt_big_c;
        end
      end
      ST_RX_WORD: begin
        if (rx_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = word_full_c;
        end
        if (last_byte_c) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = word_full_c;
          imem_addr_d  = idx_q;
          if (idx_q != last_q) idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_SEND_END: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = err_q ? ERR_BYTE : ACK_BYTE;
        end
      end
      default: ;
    endcase
    done_d      = (state_d == ST_DONE);
    core_hold_d = !((state_d == ST_DONE) && !err_d);
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: default instance plus an ADDR_W=4 instance for size limits.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        force_busy = 1'b0;
  int          busy_cnt = 0;
  int          busy4_cnt = 0;
  logic        tx_busy, tx_busy4;

  logic [7:0]  tx_data, tx_data4;
  logic        tx_start, tx_start4;
  logic        imem_we, imem_we4;
  logic [13:0] imem_addr;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_wdata, imem_wdata4;
  logic        core_hold, core_hold4, done, done4, err, err4;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_q[$];
  logic [13:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  tx4_q[$];
  int          we4_cnt = 0;
  logic [3:0]  last_a4 = '0;
  logic [31:0] last_d4 = '0;
  int          prot_viol = 0;
  logic        prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_boot_loader u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done), .err(err)
  );

  uart_boot_loader #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy4),
    .tx_data(tx_data4), .tx_start(tx_start4), .imem_we(imem_we4), .imem_addr(imem_addr4),
    .imem_wdata(imem_wdata4), .core_hold(core_hold4), .done(done4), .err(err4)
  );

  // Transmitter models: busy for 20 cycles after each start.
  assign tx_busy  = force_busy || (busy_cnt != 0);
  assign tx_busy4 = (busy4_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (tx_start4) busy4_cnt <= 20;
    else if (busy4_cnt != 0) busy4_cnt <= busy4_cnt - 1;
  end

  always @(negedge clk) begin
    if (tx_start) begin
      tx_q.push_back(tx_data);
      if (tx_busy || prev_start) prot_viol++;
    end
    prev_start = tx_start;
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (tx_start4) tx4_q.push_back(tx_data4);
    if (imem_we4) begin
      we4_cnt++;
      last_a4 = imem_addr4;
      last_d4 = imem_wdata4;
    end
  end

  task automatic clear_logs();
    @(posedge clk);
    tx_q.delete(); wa_q.delete(); wd_q.delete(); tx4_q.delete();
    we4_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic wait_hs(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_q.size() >= 1 && !tx_start && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_hs_timeout: handshake not completed, got %0d bytes, required 1", name, tx_q.size()); end
  endtask

  task automatic wait_done(input bit use4, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((use4 ? done4 : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout: done got 0, required 1", name); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    repeat (2) @(negedge clk);
    checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
    checks++; if (imem_we !== 1'b0)      begin errors++; $display("FAIL rst_imem_we: got %b required 0", imem_we); end
    checks++; if (imem_addr !== 14'h0)   begin errors++; $display("FAIL rst_imem_addr: got %h required 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0)  begin errors++; $display("FAIL rst_imem_wdata: got %h required 0", imem_wdata); end
    checks++; if (tx_data !== 8'h00)     begin errors++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (err !== 1'b0)          begin errors++; $display("FAIL rst_err: got %b required 0", err); end
    checks++; if (core_hold !== 1'b1)    begin errors++; $display("FAIL rst_core_hold: got %b required 1", core_hold); end
    rst = 1'b0;
    wait_hs("reset");
    checks++; if (tx_q.size() !== 1)     begin errors++; $display("FAIL hs_count: got %0d required 1", tx_q.size()); end
    checks++; if (tx_q[0] !== 8'hAA)     begin errors++; $display("FAIL hs_byte: got %h required aa", tx_q[0]); end
    checks++; if (core_hold !== 1'b1)    begin errors++; $display("FAIL hs_core_hold: got %b required 1", core_hold); end
  endtask

  task automatic test_load_two();
    apply_reset();
    wait_hs("load2");
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    wait_done(1'b0, "load2");
    checks++; if (wa_q.size() !== 2)        begin errors++; $display("FAIL load2_nwrites: got %0d required 2", wa_q.size()); end
    checks++; if (wa_q[0] !== 14'd0)        begin errors++; $display("FAIL load2_addr0: got %h required 0", wa_q[0]); end
    checks++; if (wd_q[0] !== 32'h13)       begin errors++; $display("FAIL load2_data0: got %h required 00000013", wd_q[0]); end
    checks++; if (wa_q[1] !== 14'd1)        begin errors++; $display("FAIL load2_addr1: got %h required 1", wa_q[1]); end
    checks++; if (wd_q[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL load2_data1: got %h required deadbeef", wd_q[1]); end
    checks++; if (tx_q.size() !== 2)        begin errors++; $display("FAIL load2_ntx: got %0d required 2", tx_q.size()); end
    checks++; if (tx_q[1] !== 8'h55)        begin errors++; $display("FAIL load2_ack: got %h required 55", tx_q[1]); end
    checks++; if (done !== 1'b1)            begin errors++; $display("FAIL load2_done: got %b required 1", done); end
    checks++; if (err !== 1'b0)             begin errors++; $display("FAIL load2_err: got %b required 0", err); end
    checks++; if (core_hold !== 1'b0)       begin errors++; $display("FAIL load2_core_hold: got %b required 0", core_hold); end
    // Traffic after completion must be ignored.
    send_word(32'h0102_0304);
    repeat (30) @(negedge clk);
    checks++; if (tx_q.size() !== 2 || wa_q.size() !== 2) begin errors++; $display("FAIL done_ignores_rx: got tx=%0d wr=%0d required tx=2 wr=2", tx_q.size(), wa_q.size()); end
    checks++; if (done !== 1'b1)            begin errors++; $display("FAIL done_sticky: got %b required 1", done); end
  endtask

  task automatic test_zero_count();
    apply_reset();
    wait_hs("zero");
    send_word(32'd0);
    wait_done(1'b0, "zero");
    checks++; if (wa_q.size() !== 0)  begin errors++; $display("FAIL zero_nwrites: got %0d required 0", wa_q.size()); end
    checks++; if (tx_q.size() !== 2)  begin errors++; $display("FAIL zero_ntx: got %0d required 2", tx_q.size()); end
    checks++; if (tx_q[1] !== 8'h55)  begin errors++; $display("FAIL zero_ack: got %h required 55", tx_q[1]); end
    checks++; if (done !== 1'b1 || err !== 1'b0 || core_hold !== 1'b0) begin errors++; $display("FAIL zero_flags: got done=%b err=%b hold=%b required 1 0 0", done, err, core_hold); end
  endtask

  task automatic test_too_big();
    apply_reset();
    wait_hs("big");
    send_word(32'd17);
    wait_done(1'b1, "big");
    checks++; if (tx4_q.size() !== 2)  begin errors++; $display("FAIL big_ntx: got %0d required 2", tx4_q.size()); end
    checks++; if (tx4_q[1] !== 8'hEE)  begin errors++; $display("FAIL big_err_byte: got %h required ee", tx4_q[1]); end
    checks++; if (err4 !== 1'b1)       begin errors++; $display("FAIL big_err: got %b required 1", err4); end
    checks++; if (done4 !== 1'b1)      begin errors++; $display("FAIL big_done: got %b required 1", done4); end
    checks++; if (core_hold4 !== 1'b1) begin errors++; $display("FAIL big_core_hold: got %b required 1", core_hold4); end
    checks++; if (we4_cnt !== 0)       begin errors++; $display("FAIL big_nwrites: got %0d required 0", we4_cnt); end
  endtask

  task automatic test_full_depth();
    apply_reset();
    wait_hs("full");
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'h1000_0000 + 32'(i));
    wait_done(1'b1, "full");
    checks++; if (we4_cnt !== 16)         begin errors++; $display("FAIL full_nwrites: got %0d required 16", we4_cnt); end
    checks++; if (last_a4 !== 4'd15)      begin errors++; $display("FAIL full_last_addr: got %0d required 15", last_a4); end
    checks++; if (last_d4 !== 32'h1000000F) begin errors++; $display("FAIL full_last_data: got %h required 1000000f", last_d4); end
    checks++; if (tx4_q.size() !== 2 || tx4_q[1] !== 8'h55) begin errors++; $display("FAIL full_ack: got n=%0d byte=%h required n=2 byte=55", tx4_q.size(), tx4_q[1]); end
    checks++; if (err4 !== 1'b0 || core_hold4 !== 1'b0) begin errors++; $display("FAIL full_flags: got err=%b hold=%b required 0 0", err4, core_hold4); end
  endtask

  task automatic test_busy_hold();
    @(negedge clk);
    rst = 1'b1;
    force_busy = 1'b1;
    clear_logs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL busy_no_start: got %0d starts required 0", tx_q.size()); end
    force_busy = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL busy_one_start: got %0d starts required 1", tx_q.size()); end
    checks++; if (tx_q[0] !== 8'hAA) begin errors++; $display("FAIL busy_hs_byte: got %h required aa", tx_q[0]); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    wait_hs("mid");
    send_word(32'd1);
    send_byte(8'h78);
    send_byte(8'h56);
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    @(negedge clk);
    checks++; if (tx_start !== 1'b0 || imem_we !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_tx: got start=%b we=%b data=%h required 0 0 00", tx_start, imem_we, tx_data); end
    checks++; if (imem_addr !== 14'h0 || imem_wdata !== 32'h0) begin errors++; $display("FAIL mid_rst_mem: got addr=%h wdata=%h required 0 0", imem_addr, imem_wdata); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || core_hold !== 1'b1) begin errors++; $display("FAIL mid_rst_flags: got done=%b err=%b hold=%b required 0 0 1", done, err, core_hold); end
    rst = 1'b0;
    wait_hs("mid_rehs");
    checks++; if (tx_q[0] !== 8'hAA) begin errors++; $display("FAIL mid_rehs_byte: got %h required aa", tx_q[0]); end
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_done(1'b0, "mid_reload");
    checks++; if (wa_q.size() !== 1)        begin errors++; $display("FAIL mid_nwrites: got %0d required 1", wa_q.size()); end
    checks++; if (wa_q[0] !== 14'd0)        begin errors++; $display("FAIL mid_addr0: got %h required 0", wa_q[0]); end
    checks++; if (wd_q[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_data0: got %h required cafef00d", wd_q[0]); end
    checks++; if (tx_q.size() !== 2 || tx_q[1] !== 8'h55) begin errors++; $display("FAIL mid_ack: got n=%0d byte=%h required n=2 byte=55", tx_q.size(), tx_q[1]); end
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_zero_count();
    test_too_big();
    test_full_depth();
    test_busy_hold();
    test_mid_reset();
    checks++;
    if (prot_viol !== 0) begin errors++; $display("FAIL tx_protocol: got %0d violations required 0", prot_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter HS_BYTE, default 8'hAA, meaning the handshake byte sent to the host.
REQ-003 SHALL have parameter ACK_BYTE, default 8'h55, meaning the success byte sent after the image.
REQ-004 SHALL have parameter ERR_BYTE, default 8'hEE, meaning the failure byte.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port rx_data  input  8  byte from the byte-level UART receiver.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-009 SHALL have port tx_busy  input  1  byte-level UART transmitter busy.
REQ-010 SHALL have port tx_data  output  8  byte to transmit.
REQ-011 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-012 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-013 SHALL have port imem_addr  output  ADDR_W  word address.
REQ-014 SHALL have port imem_wdata  output  32  word to write.
REQ-015 SHALL have port core_hold  output  1  holds the core in reset until the load completes.
REQ-016 SHALL have ports done and err  output  1 each  load finished; load failed.

Function
REQ-017 SHALL implement states SEND_HS, WAIT_HS, RX_COUNT, RX_WORD, SEND_END, WAIT_END, DONE.
REQ-018 SEND_HS: when tx_busy==0, drive tx_data=HS_BYTE and tx_start=1 for exactly one cycle, then go to WAIT_HS.
REQ-019 WAIT_HS: wait one cycle, then wait for tx_busy==0, then go to RX_COUNT; rx_valid in SEND_HS/WAIT_HS is dropped.
REQ-020 RX_COUNT: take 4 bytes, little-endian, as 32-bit word count N.
REQ-021 If N==0, go directly to SEND_END with ACK_BYTE.
REQ-022 If N > 2^ADDR_W, go to SEND_END with ERR_BYTE and set err; no memory writes occur.
REQ-023 RX_WORD: assemble 4 bytes little-endian; on the 4th byte, in the next cycle, pulse imem_we=1 for one cycle with imem_wdata=word and imem_addr=word index (0..N-1).
REQ-024 After write N-1, go to SEND_END with ACK_BYTE.
REQ-025 SEND_END/WAIT_END SHALL use the same tx handshake as REQ-018/019, then go to DONE.
REQ-026 In DONE: done=1, core_hold=0, rx_valid ignored, no further tx; remain in DONE until rst.
REQ-027 core_hold SHALL be 1 in every state except DONE-with-err==0; after an error the core stays held.
REQ-028 tx_start SHALL never assert while tx_busy==1, and never in two consecutive cycles.
REQ-029 Byte counter SHALL be 2 bits and wrap 3->0 after each word or count field; word index SHALL count up to N-1 without wrap.

Reset
REQ-030 rst==1 at any clock edge, including mid-transfer, SHALL enter SEND_HS, clear the counters and the partial word, and set tx_start=0, imem_we=0, imem_addr=0, imem_wdata=0, tx_data=0, done=0, err=0, core_hold=1.
REQ-031 After reset release, the handshake SHALL be re-sent; a partially loaded image is not resumed.

Structure
REQ-032 State encoding and default HS/ACK/ERR byte constants SHALL live in a shared package, loader_pkg.
REQ-033 The block SHALL be a single module; it connects to the existing uart_rx/uart_tx byte interfaces and does not instantiate them.

Verification
REQ-034 Reset, tx_busy=0 -> tx_start pulses once with tx_data=0xAA; core_hold=1.
REQ-035 Count 02 00 00 00, words 0x00000013 and 0xDEADBEEF (bytes 13 00 00 00 EF BE AD DE) -> writes addr0=0x00000013 and addr1=0xDEADBEEF; tx 0x55; done=1; core_hold=0.
REQ-036 Count 00 00 00 00 -> no imem_we; tx 0x55; done=1.
REQ-037 ADDR_W=4, count 17 -> tx 0xEE, err=1, done=1, core_hold=1, no writes.
REQ-038 tx_busy held high for 100 cycles during SEND_HS -> tx_start stays 0 until busy falls, then exactly one pulse.
REQ-039 rst asserted after 2 of 4 data bytes -> outputs return to reset values; next sequence re-sends 0xAA; a full reload writes correctly from addr 0.
